// File: rtl/pad_in_filter_if.sv
// Bundle between the input pad vector, the filter, and its consumers.
// mclk and puc_rst stay plain ports on the filter itself.
interface pad_in_filter_if #(
  parameter int WIDTH = 4
);
  logic             deb_en;
  logic [WIDTH-1:0] pad_i;
  logic [WIDTH-1:0] din_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;

  modport master (output deb_en, pad_i, input din_o, rise_o, fall_o);
  modport slave  (input deb_en, pad_i, output din_o, rise_o, fall_o);
endinterface

// File: rtl/pad_in_filter.sv
// Per-bit pad conditioning: synchroniser chain, debounce counter, and a
// registered clean level with one-cycle rise/fall event pulses.
module pad_in_filter #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic              mclk,
  input  logic              puc_rst,
  pad_in_filter_if.slave    bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] din_next;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [CW-1:0]    cnt_q    [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= {WIDTH{RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= bus.pad_i;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
    end
  end

  // A level is accepted only after it differs from din for DEBOUNCE_CYCLES
  // consecutive edges; any agreement or bypass discards the partial count.
  always_comb begin
    din_next = din_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (!bus.deb_en) begin
        din_next[i] = s[i];
      end else if (s[i] != din_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          din_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      din_q  <= {WIDTH{RESET_LEVEL}};
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      din_q  <= din_next;
      rise_q <= din_next & ~din_q;
      fall_q <= ~din_next & din_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_next[i];
      end
    end
  end

  assign bus.din_o  = din_q;
  assign bus.rise_o = rise_q;
  assign bus.fall_o = fall_q;

endmodule

// File: tb/tb_pad_in_filter.sv
// Self-checking bench for pad_in_filter: directed steps plus random pad
// activity, compared every edge against a history-based reference model.
module tb_pad_in_filter;

  localparam int       WIDTH = 4;
  localparam int       SYNC  = 2;
  localparam int       DEB   = 16;
  localparam bit       RL    = 1'b0;
  localparam int       HIST  = 16384;

  logic mclk;
  logic puc_rst;

  pad_in_filter_if #(.WIDTH(WIDTH)) bus ();

  pad_in_filter #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_LEVEL(RL)
  ) dut (
    .mclk(mclk),
    .puc_rst(puc_rst),
    .bus(bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: raw pad history per edge, s derived by pure delay.
  logic [WIDTH-1:0] pad_hist [HIST];
  int               edge_no    = 0;
  int               last_reset = 0;
  logic [WIDTH-1:0] m_din  = {WIDTH{RL}};
  logic [WIDTH-1:0] m_rise = '0;
  logic [WIDTH-1:0] m_fall = '0;
  int               run [WIDTH];

  task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] nd;
    pad_hist[edge_no] = bus.pad_i;
    if (puc_rst) begin
      last_reset = edge_no;
      m_din  = {WIDTH{RL}};
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < WIDTH; i++) run[i] = 0;
    end else begin
      s  = (edge_no - SYNC > last_reset) ? pad_hist[edge_no-SYNC] : {WIDTH{RL}};
      nd = m_din;
      for (int i = 0; i < WIDTH; i++) begin
        if (!bus.deb_en) begin
          nd[i]  = s[i];
          run[i] = 0;
        end else if (s[i] == m_din[i]) begin
          run[i] = 0;
        end else begin
          run[i]++;
          if (run[i] == DEB) begin
            nd[i]  = s[i];
            run[i] = 0;
          end
        end
      end
      m_rise = nd & ~m_din;
      m_fall = ~nd & m_din;
      m_din  = nd;
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    edge_no++;
    model_edge();
    #1;
    check_output("din",       bus.din_o,  m_din);
    check_output("rise",      bus.rise_o, m_rise);
    check_output("fall",      bus.fall_o, m_fall);
    check_output("rise&fall", bus.rise_o & bus.fall_o, '0);
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] pad, input logic en,
                                input int cycles);
    bus.pad_i  = pad;
    bus.deb_en = en;
    for (int n = 0; n < cycles; n++) tick();
  endtask

  // Counts edges until din[b] changes (bounded) and checks that count.
  task automatic wait_change(input string tag, input int b, input int exp_edges);
    logic start;
    int   n;
    start = bus.din_o[b];
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (bus.din_o[b] !== start) break;
    end
    check_int(tag, n, exp_edges);
  endtask

  initial begin
    logic [WIDTH-1:0] ev;
    int rises;
    int falls;
    for (int i = 0; i < WIDTH; i++) run[i] = 0;
    puc_rst    = 1'b1;
    bus.pad_i  = 4'hF;
    bus.deb_en = 1'b1;

    // Reset held 3 edges with pads high
    for (int n = 0; n < 3; n++) begin
      tick();
      check_output("rst_din",  bus.din_o,  4'h0);
      check_output("rst_rise", bus.rise_o, 4'h0);
    end
    puc_rst = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      check_output("post_rst_din_low", bus.din_o, 4'h0);
    end
    tick();
    check_output("post_rst_din_18", bus.din_o,  4'hF);
    check_output("post_rst_rise",   bus.rise_o, 4'hF);
    tick();
    check_output("post_rst_rise_clr", bus.rise_o, 4'h0);

    // Clean falling then rising edge on bit 0
    bus.pad_i = 4'hE;
    wait_change("clean_fall_lat", 0, 18);
    check_output("clean_fall_pulse", bus.fall_o, 4'h1);
    apply_stimulus(4'hE, 1'b1, 5);
    bus.pad_i = 4'hF;
    wait_change("clean_rise_lat", 0, 18);
    check_output("clean_rise_pulse", bus.rise_o, 4'h1);
    check_output("clean_others", bus.din_o, 4'hF);

    // Glitch rejection on bit 1
    apply_stimulus(4'h0, 1'b1, 25);
    ev = '0;
    bus.pad_i = 4'h2;
    for (int n = 0; n < 15; n++) begin tick(); ev |= bus.rise_o | bus.fall_o; end
    bus.pad_i = 4'h0;
    for (int n = 0; n < 25; n++) begin tick(); ev |= bus.rise_o | bus.fall_o; end
    check_output("glitch15_din", bus.din_o, 4'h0);
    check_output("glitch15_ev",  ev,        4'h0);
    rises = 0;
    falls = 0;
    bus.pad_i = 4'h2;
    for (int n = 0; n < 16; n++) begin tick(); rises += int'(bus.rise_o[1]); end
    bus.pad_i = 4'h0;
    for (int n = 0; n < 40; n++) begin
      tick();
      rises += int'(bus.rise_o[1]);
      falls += int'(bus.fall_o[1]);
    end
    check_int("glitch16_rises", rises, 1);
    check_int("glitch16_falls", falls, 1);

    // Bypass latency on bit 2, then deb_en toggled mid-count
    apply_stimulus(4'h4, 1'b0, 6);
    bus.pad_i = 4'h0;
    wait_change("bypass_lat", 2, 3);
    check_output("bypass_fall", bus.fall_o, 4'h4);
    apply_stimulus(4'h4, 1'b1, 8);
    apply_stimulus(4'h4, 1'b0, 1);
    apply_stimulus(4'h0, 1'b1, 6);
    apply_stimulus(4'h0, 1'b0, 1);
    apply_stimulus(4'h0, 1'b1, 10);
    apply_stimulus(4'h4, 1'b1, 8);
    bus.deb_en = 1'b0;
    tick();
    bus.deb_en = 1'b1;
    apply_stimulus(4'h0, 1'b1, 25);

    // Reset mid-count on bit 3
    apply_stimulus(4'h8, 1'b1, 10);
    puc_rst = 1'b1;
    tick();
    check_output("midrst_din", bus.din_o, 4'h0);
    puc_rst = 1'b0;
    wait_change("midrst_lat", 3, 18);
    check_output("midrst_rise", bus.rise_o, 4'h8);
    apply_stimulus(4'h0, 1'b1, 25);

    // Independence: short alternation rejected, long alternation accepted
    ev = '0;
    for (int r = 0; r < 8; r++) begin
      bus.pad_i = (r % 2 == 0) ? 4'h5 : 4'hA;
      for (int n = 0; n < 8; n++) begin tick(); ev |= bus.rise_o | bus.fall_o; end
    end
    check_output("alt8_din", bus.din_o, 4'h0);
    check_output("alt8_ev",  ev,        4'h0);
    for (int r = 0; r < 6; r++) apply_stimulus((r % 2 == 0) ? 4'h5 : 4'hA, 1'b1, 20);

    // Random pad levels, hold lengths, bypass and resets
    for (int seg = 0; seg < 60; seg++) begin
      puc_rst = ($urandom_range(0, 24) == 0);
      apply_stimulus(WIDTH'($urandom), ($urandom_range(0, 7) != 0),
                     int'($urandom_range(1, 24)));
      puc_rst = 1'b0;
    end
    apply_stimulus(4'h0, 1'b1, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
